// File: rtl/alu_issue_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_buffer
//  Purpose  : Two-entry elastic (skid) buffer in front of the ALU. Accepts
//             {aluop, a, b} bundles over a valid/ready handshake and presents
//             them in order to the ALU stage. in_ready and out_valid depend
//             only on registered state, so ALU backpressure never reaches the
//             upstream ready path combinationally.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK        in   1       system clock, rising-edge
//    nRST       in   1       asynchronous active-low reset
//    in_valid   in   1       upstream offers a bundle
//    in_ready   out  1       buffer can accept a bundle
//    in_aluop   in   OP_W    opcode of offered bundle
//    in_a       in   DATA_W  operand A of offered bundle
//    in_b       in   DATA_W  operand B of offered bundle
//    flush      in   1       synchronous discard of all buffered bundles
//    out_valid  out  1       head bundle valid for ALU
//    out_ready  in   1       ALU consumes head this cycle
//    out_aluop  out  OP_W    head opcode
//    out_a      out  DATA_W  head operand A
//    out_b      out  DATA_W  head operand B
//    count      out  2       occupancy 0..2
// ============================================================================
module alu_issue_buffer #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_aluop,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_aluop,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [1:0]        count
);

    // State encoding equals occupancy so count is a direct view of the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [OP_W-1:0]     head_op_q,   head_op_d;
    logic [DATA_W-1:0]   head_a_q,    head_a_d;
    logic [DATA_W-1:0]   head_b_q,    head_b_d;
    logic [OP_W-1:0]     skid_op_q,   skid_op_d;
    logic [DATA_W-1:0]   skid_a_q,    skid_a_d;
    logic [DATA_W-1:0]   skid_b_q,    skid_b_d;

    logic push;
    logic pop;

    // Handshake outputs come straight from the state register.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign count     = state_q;
    assign out_aluop = head_op_q;
    assign out_a     = head_a_q;
    assign out_b     = head_b_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        head_op_d = head_op_q;
        head_a_d  = head_a_q;
        head_b_d  = head_b_q;
        skid_op_d = skid_op_q;
        skid_a_d  = skid_a_q;
        skid_b_d  = skid_b_q;

        if (flush) begin
            // Flush wins over any push/pop; data regs keep stale contents,
            // which out_valid=0 masks.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d   = ST_ONE;
                        head_op_d = in_aluop;
                        head_a_d  = in_a;
                        head_b_d  = in_b;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        // Head replaced in the same cycle it is consumed.
                        head_op_d = in_aluop;
                        head_a_d  = in_a;
                        head_b_d  = in_b;
                    end else if (push) begin
                        state_d   = ST_FULL;
                        skid_op_d = in_aluop;
                        skid_a_d  = in_a;
                        skid_b_d  = in_b;
                    end else if (pop) begin
                        state_d   = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can occur.
                    if (pop) begin
                        state_d   = ST_ONE;
                        head_op_d = skid_op_q;
                        head_a_d  = skid_a_q;
                        head_b_d  = skid_b_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= ST_EMPTY;
            head_op_q <= '0;
            head_a_q  <= '0;
            head_b_q  <= '0;
            skid_op_q <= '0;
            skid_a_q  <= '0;
            skid_b_q  <= '0;
        end else begin
            state_q   <= state_d;
            head_op_q <= head_op_d;
            head_a_q  <= head_a_d;
            head_b_q  <= head_b_d;
            skid_op_q <= skid_op_d;
            skid_a_q  <= skid_a_d;
            skid_b_q  <= skid_b_d;
        end
    end

endmodule
`default_nettype wire
